// File: rtl/frame_buffer_manager_if.sv
// Pixel write channel between the drawing logic (master) and the frame buffer (slave).
interface frame_buffer_manager_if #(
  parameter int COL_W = 9,
  parameter int ROW_W = 8,
  parameter int BPP   = 1
);
  logic             wr_valid;
  logic             wr_ready;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [BPP-1:0]   wr_idx;
  logic             wr_oob;

  modport master (
    output wr_valid, wr_col, wr_row, wr_idx,
    input  wr_ready, wr_oob
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_idx,
    output wr_ready, wr_oob
  );
endinterface

// File: rtl/frame_buffer_manager.sv
// Frame buffer between the drawing logic and the LT24 LCD driver.
// Stores one BPP-bit colour index per pixel in a simple dual-port RAM, clears
// it after reset or on request, accepts pixel writes and streams the buffer
// to the LCD in raster order as RGB565.
// Optional feature macro: FBM_PALETTE_EN (programmable palette instead of the
// fixed grey ramp).
module frame_buffer_manager #(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int BPP       = 1,
  parameter int CLEAR_IDX = 0,
  localparam int PIXELS   = H_RES * V_RES,
  localparam int ADDR_W   = $clog2(PIXELS),
  localparam int COL_W    = $clog2(H_RES),
  localparam int ROW_W    = $clog2(V_RES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  frame_buffer_manager_if.slave        wr,
  output logic                         busy,
  output logic                         frame_start,
  input  logic                         lcd_initialized,
  input  logic                         lcd_done,
  output logic                         lcd_print,
  output logic [15:0]                  lcd_pixel_rgb
`ifdef FBM_PALETTE_EN
  ,
  input  logic                         pal_we,
  input  logic [BPP-1:0]               pal_addr,
  input  logic [15:0]                  pal_data
`endif
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [COL_W:0]    COL_LIM   = (COL_W + 1)'(H_RES);
  localparam logic [ROW_W:0]    ROW_LIM   = (ROW_W + 1)'(V_RES);
  localparam logic [BPP-1:0]    CLR_VAL   = BPP'(CLEAR_IDX);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              bubble_q, bubble_d;
  logic              frame_start_q, frame_start_d;
  logic              wr_pend_q, wr_pend_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [ROW_W-1:0]  wr_row_q, wr_row_d;
  logic [BPP-1:0]    wr_idx_q, wr_idx_d;

  logic [BPP-1:0]    mem [PIXELS];
  logic [BPP-1:0]    ram_q;

  logic              run, accept, done_acc, wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [BPP-1:0]    ram_wdata;

  assign run         = (state_q == ST_RUN);
  assign accept      = wr.wr_valid & wr.wr_ready;
  assign done_acc    = lcd_done & lcd_print;
  assign wr_in_range = ({1'b0, wr_col_q} < COL_LIM) && ({1'b0, wr_row_q} < ROW_LIM);
  assign wr_addr     = ADDR_W'(wr_row_q) * ADDR_W'(H_RES) + ADDR_W'(wr_col_q);

  assign wr.wr_ready = run & ~clear_req;
  assign wr.wr_oob   = wr_pend_q & ~wr_in_range;
  assign busy        = ~run;
  assign lcd_print   = run & ~bubble_q;
  assign frame_start = frame_start_q;

  // Next-state logic: clear sweep, LCD wait, scan pointer and write capture.
  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    scan_addr_d   = scan_addr_q;
    bubble_d      = done_acc;
    frame_start_d = 1'b0;
    wr_pend_d     = accept;
    wr_col_d      = wr_col_q;
    wr_row_d      = wr_row_q;
    wr_idx_d      = wr_idx_q;
    if (accept) begin
      wr_col_d = wr.wr_col;
      wr_row_d = wr.wr_row;
      wr_idx_d = wr.wr_idx;
    end
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lcd_initialized) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = '0;
          scan_addr_d = '0;
          bubble_d    = 1'b0;
        end else if (done_acc) begin
          scan_addr_d   = (scan_addr_q == LAST_ADDR) ? '0 : scan_addr_q + ADDR_W'(1);
          frame_start_d = (scan_addr_q == LAST_ADDR);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Control registers; reset restarts the clear sweep from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_addr_q    <= '0;
      scan_addr_q   <= '0;
      bubble_q      <= 1'b0;
      frame_start_q <= 1'b0;
      wr_pend_q     <= 1'b0;
      wr_col_q      <= '0;
      wr_row_q      <= '0;
      wr_idx_q      <= '0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      scan_addr_q   <= scan_addr_d;
      bubble_q      <= bubble_d;
      frame_start_q <= frame_start_d;
      wr_pend_q     <= wr_pend_d;
      wr_col_q      <= wr_col_d;
      wr_row_q      <= wr_row_d;
      wr_idx_q      <= wr_idx_d;
    end
  end

  // Single RAM write port: the clear sweep owns it while clearing.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_idx_q;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = CLR_VAL;
    end else if (wr_pend_q && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  // RAM write side.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Registered RAM read of the scan pixel; same-address writes return old data.
  always_ff @(posedge clk) begin
    if (reset) ram_q <= '0;
    else       ram_q <= mem[scan_addr_q];
  end

`ifdef FBM_PALETTE_EN
  localparam int PAL_N = 1 << BPP;
  logic [15:0] pal_q [PAL_N];
  logic [15:0] pal_d [PAL_N];

  // Palette update, accepted in any state.
  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_addr] = pal_data;
  end

  // Palette registers: entry 0 black, all others white after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= (i == 0) ? 16'h0000 : 16'hFFFF;
    end else begin
      pal_q <= pal_d;
    end
  end

  assign lcd_pixel_rgb = pal_q[ram_q];
`else
  logic [5:0] grey;

  // Grey ramp: the index is repeated MSB-first to fill six bits.
  for (genvar gi = 0; gi < 6; gi++) begin : g_grey
    assign grey[5-gi] = ram_q[BPP-1-(gi % BPP)];
  end

  assign lcd_pixel_rgb = {grey[5:1], grey, grey[5:1]};
`endif

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Directed bench for frame_buffer_manager on a 4x3 frame.
// dut uses BPP=1 for the scan/write/clear scenarios; dut2 uses BPP=2 with its
// scan parked on pixel 0 to check the index-to-RGB mapping.
module tb_frame_buffer_manager;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int PIX = H * V;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_req = 1'b0;
  logic lcd_initialized = 1'b1;
  logic lcd_done = 1'b0;
  logic busy, frame_start, lcd_print;
  logic [15:0] rgb;
  logic busy2, fs2, print2;
  logic [15:0] rgb2;
`ifdef FBM_PALETTE_EN
  logic pal_we = 1'b0;
  logic pal_addr = 1'b0;
  logic [15:0] pal_data = 16'h0;
  logic pal_we2 = 1'b0;
  logic [1:0] pal_addr2 = 2'd0;
  logic [15:0] pal_data2 = 16'h0;
`endif

  int total = 0;
  int bad = 0;
  bit exp_mem [PIX];
  int scan_pos = 0;

  always #5 clk = ~clk;

  frame_buffer_manager_if #(.COL_W(2), .ROW_W(2), .BPP(1)) wif ();
  frame_buffer_manager_if #(.COL_W(2), .ROW_W(2), .BPP(2)) wif2 ();

  frame_buffer_manager #(.H_RES(H), .V_RES(V), .BPP(1), .CLEAR_IDX(0)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .wr(wif),
    .busy(busy), .frame_start(frame_start), .lcd_initialized(lcd_initialized),
    .lcd_done(lcd_done), .lcd_print(lcd_print), .lcd_pixel_rgb(rgb)
`ifdef FBM_PALETTE_EN
    , .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
`endif
  );

  frame_buffer_manager #(.H_RES(H), .V_RES(V), .BPP(2), .CLEAR_IDX(0)) dut2 (
    .clk(clk), .reset(reset), .clear_req(1'b0), .wr(wif2),
    .busy(busy2), .frame_start(fs2), .lcd_initialized(lcd_initialized),
    .lcd_done(1'b0), .lcd_print(print2), .lcd_pixel_rgb(rgb2)
`ifdef FBM_PALETTE_EN
    , .pal_we(pal_we2), .pal_addr(pal_addr2), .pal_data(pal_data2)
`endif
  );

  // Consume ndone pixels, asserting lcd_done on every period-th cycle that
  // lcd_print is high; checks pixel data, the post-done bubble and frame_start.
  task automatic scan(input int ndone, input int period, output int fs_cnt);
    int got, cyc;
    bit bub, fs_exp;
    logic [15:0] exp_rgb;
    got = 0; cyc = 0; bub = 0; fs_exp = 0; fs_cnt = 0;
    while (1) begin
      total++;
      if (lcd_print !== logic'(!bub)) begin
        bad++;
        $display("FAIL scan_print pos=%0d got=%b want=%b", scan_pos, lcd_print, !bub);
      end
      total++;
      if (frame_start !== logic'(fs_exp)) begin
        bad++;
        $display("FAIL scan_frame_start pos=%0d got=%b want=%b", scan_pos, frame_start, fs_exp);
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (got == ndone || cyc >= 1000) break;
      bub = 0; fs_exp = 0;
      if (lcd_print === 1'b1 && (cyc % period) == 0) begin
        exp_rgb = exp_mem[scan_pos] ? 16'hFFFF : 16'h0000;
        total++;
        if (rgb !== exp_rgb) begin
          bad++;
          $display("FAIL scan_pixel addr=%0d got=%h want=%h", scan_pos, rgb, exp_rgb);
        end
        lcd_done = 1'b1;
        bub = 1;
        fs_exp = (scan_pos == PIX - 1);
        scan_pos = (scan_pos + 1) % PIX;
        got++;
      end else begin
        lcd_done = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    lcd_done = 1'b0;
    if (got != ndone) begin
      bad++;
      $display("FAIL scan_timeout got=%0d want=%0d", got, ndone);
    end
    @(negedge clk);
  endtask

  // One accepted write on the main DUT; returns at the negedge after acceptance.
  task automatic wr_px(input logic [1:0] c, input logic [1:0] r, input logic i);
    wif.wr_valid = 1'b1;
    wif.wr_col = c;
    wif.wr_row = r;
    wif.wr_idx = i;
    #1;
    total++;
    if (wif.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_ready col=%0d row=%0d got=%b want=1", c, r, wif.wr_ready);
    end
    @(negedge clk);
    wif.wr_valid = 1'b0;
  endtask

  // Count cycles with busy high, starting at the current negedge.
  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt != PIX + 1) begin
      bad++;
      $display("FAIL %s_busy_cycles got=%0d want=%0d", name, cnt, PIX + 1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (lcd_print !== 1'b0) begin bad++; $display("FAIL reset_lcd_print got=%b want=0", lcd_print); end
    total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b want=0", wif.wr_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
    total++; if (wif.wr_oob !== 1'b0) begin bad++; $display("FAIL reset_wr_oob got=%b want=0", wif.wr_oob); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
    total++; if (rgb !== 16'h0000) begin bad++; $display("FAIL reset_rgb got=%h want=0000", rgb); end
    $display("test_reset done");
  endtask

  task automatic test_clear();
    int fs;
    reset = 1'b0;
    lcd_done = 1'b1;  // must be ignored while not printing
    wait_ready("clear");
    lcd_done = 1'b0;
    scan_pos = 0;
    scan(PIX, 2, fs);
    total++; if (fs != 1) begin bad++; $display("FAIL clear_frame_count got=%0d want=1", fs); end
    $display("test_clear done");
  endtask

  task automatic test_write();
    int fs;
    wr_px(2'd2, 2'd1, 1'b1); exp_mem[6] = 1;
    total++; if (wif.wr_oob !== 1'b0) begin bad++; $display("FAIL write_oob got=%b want=0", wif.wr_oob); end
    wr_px(2'd0, 2'd2, 1'b1); exp_mem[8] = 1;
    wr_px(2'd3, 2'd2, 1'b1); exp_mem[11] = 1;
    repeat (2) @(negedge clk);
    scan(PIX, 2, fs);
    $display("test_write done");
  endtask

  task automatic test_oob();
    int fs, pulses;
    wr_px(2'd1, 2'd3, 1'b1);
    pulses = (wif.wr_oob === 1'b1) ? 1 : 0;
    total++; if (wif.wr_oob !== 1'b1) begin bad++; $display("FAIL oob_pulse got=%b want=1", wif.wr_oob); end
    repeat (3) begin
      @(negedge clk);
      if (wif.wr_oob === 1'b1) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL oob_pulse_count got=%0d want=1", pulses); end
    scan(PIX, 2, fs);
    $display("test_oob done");
  endtask

  task automatic test_handshake();
    int fs;
    scan(3 * PIX, 3, fs);
    total++; if (fs != 3) begin bad++; $display("FAIL handshake_frame_count got=%0d want=3", fs); end
    $display("test_handshake done");
  endtask

  task automatic test_mid_clear();
    int fs;
    scan(5, 2, fs);
    clear_req = 1'b1;
    wif.wr_valid = 1'b1;
    wif.wr_col = 2'd0;
    wif.wr_row = 2'd0;
    wif.wr_idx = 1'b1;
    #1;
    total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL midclr_wr_ready got=%b want=0", wif.wr_ready); end
    @(negedge clk);
    clear_req = 1'b0;
    wif.wr_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midclr_busy got=%b want=1", busy); end
    total++; if (lcd_print !== 1'b0) begin bad++; $display("FAIL midclr_print got=%b want=0", lcd_print); end
    wait_ready("midclr");
    for (int k = 0; k < PIX; k++) exp_mem[k] = 0;
    scan_pos = 0;
    scan(PIX, 2, fs);
    $display("test_mid_clear done");
  endtask

  task automatic test_map();
    logic [15:0] want;
    logic [1:0] idx_tab [3];
    logic [15:0] want_tab [3];
    idx_tab[0] = 2'd2; idx_tab[1] = 2'd3; idx_tab[2] = 2'd1;
`ifdef FBM_PALETTE_EN
    want_tab[0] = 16'hF800; want_tab[1] = 16'hFFFF; want_tab[2] = 16'hFFFF;
    pal_we2 = 1'b1; pal_addr2 = 2'd2; pal_data2 = 16'hF800;
    @(negedge clk);
    pal_we2 = 1'b0;
`else
    want_tab[0] = 16'hAD55; want_tab[1] = 16'hFFFF; want_tab[2] = 16'h52AA;
`endif
    for (int t = 0; t < 3; t++) begin
      wif2.wr_valid = 1'b1;
      wif2.wr_col = 2'd0;
      wif2.wr_row = 2'd0;
      wif2.wr_idx = idx_tab[t];
      #1;
      total++; if (wif2.wr_ready !== 1'b1) begin bad++; $display("FAIL map_wr_ready idx=%0d got=%b want=1", idx_tab[t], wif2.wr_ready); end
      @(negedge clk);
      wif2.wr_valid = 1'b0;
      repeat (2) @(negedge clk);
      want = want_tab[t];
      total++; if (rgb2 !== want) begin bad++; $display("FAIL map_rgb idx=%0d got=%h want=%h", idx_tab[t], rgb2, want); end
      total++; if (print2 !== 1'b1) begin bad++; $display("FAIL map_print got=%b want=1", print2); end
    end
    $display("test_map done");
  endtask

  initial begin
    wif.wr_valid = 1'b0; wif.wr_col = '0; wif.wr_row = '0; wif.wr_idx = '0;
    wif2.wr_valid = 1'b0; wif2.wr_col = '0; wif2.wr_row = '0; wif2.wr_idx = '0;
    for (int k = 0; k < PIX; k++) exp_mem[k] = 0;
    test_reset();
    test_clear();
    test_write();
    test_oob();
    test_handshake();
    test_mid_clear();
    test_map();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit reached");
  end
endmodule
